// File: rtl/modulo_n_down_timer.sv
// modulo_n_down_timer
//   Modulo-N down counter with a small IDLE/RUN/DONE controller. Counts
//   N-1 .. 0 on enabled cycles while running, then either reloads to N-1
//   (auto-reload) or parks in DONE (one-shot). A registered one-cycle tc
//   pulse marks every terminal count.
//
// Parameters
//   N      counter modulus, count range 0..N-1 (N >= 2)
//   WIDTH  counter width (WIDTH >= clog2(N))
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (IDLE, Q = N-1, tc = 0)
//   start     begin counting (IDLE) / restart from N-1 (DONE)
//   stop      abort and return to IDLE, Q held
//   en        count-enable tick, one decrement per enabled RUN cycle
//   load      load Q from load_val, clamped to N-1
//   load_val  value to load
//   reload    1 = auto-reload at terminal count, 0 = one-shot
//   Q         current count (registered)
//   busy      high while in RUN
//   done      high while in DONE
//   tc        registered terminal-count pulse
//   Input priority at every edge: stop > load > start > en.
module modulo_n_down_timer #(
  parameter int N     = 10,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             reload,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(N - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;

  // Out-of-range load values saturate to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_Q) ? MAX_Q : v;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      Q     <= MAX_Q;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      Q     <= q_nxt;
      tc    <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = Q;
    tc_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (load) begin
          q_nxt = clamp_load(load_val);
        end else if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // start is deliberately not decoded here: a running timer ignores it.
        if (stop) begin
          state_nxt = IDLE;
        end else if (load) begin
          q_nxt = clamp_load(load_val);
        end else if (en) begin
          if (Q != '0) begin
            q_nxt = Q - WIDTH'(1);
          end else begin
            tc_nxt = 1'b1;
            if (reload) begin
              q_nxt = MAX_Q;
            end else begin
              state_nxt = DONE;
            end
          end
        end
      end
      DONE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (load) begin
          q_nxt     = clamp_load(load_val);
          state_nxt = IDLE;
        end else if (start) begin
          q_nxt     = MAX_Q;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_modulo_n_down_timer.sv
module tb_modulo_n_down_timer;

  localparam int N     = 10;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             reload = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             done;
  logic             tc;

  int n_cmp = 0;
  int n_bad = 0;

  modulo_n_down_timer #(.N(N), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en),
    .load(load), .load_val(load_val), .reload(reload),
    .Q(Q), .busy(busy), .done(done), .tc(tc)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = idle, 1 = running, 2 = finished.
  int m_mode = 0;
  int m_q    = N - 1;
  int m_tc   = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0;
      m_q    = N - 1;
      m_tc   = 0;
    end else begin
      m_tc = 0;
      if (stop) begin
        m_mode = 0;
      end else if (load) begin
        m_q = (int'(load_val) > N - 1) ? N - 1 : int'(load_val);
        if (m_mode == 2) m_mode = 0;
      end else if (start && m_mode != 1) begin
        if (m_mode == 2) m_q = N - 1;
        m_mode = 1;
      end else if (m_mode == 1 && en) begin
        if (m_q > 0) begin
          m_q = m_q - 1;
        end else begin
          m_tc = 1;
          if (reload) m_q = N - 1;
          else        m_mode = 2;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_Q",    int'(Q),    m_q);
      chk("model_busy", int'(busy), (m_mode == 1) ? 1 : 0);
      chk("model_done", int'(done), (m_mode == 2) ? 1 : 0);
      chk("model_tc",   int'(tc),   m_tc);
    end
  end

  task automatic step(input logic st, input logic sp, input logic e,
                      input logic ld, input logic [WIDTH-1:0] lv);
    start = st; stop = sp; en = e; load = ld; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  int tc_cnt;
  bit busy_ok;

  initial begin
    @(posedge clk);
    #1;
    cmp_on = 1'b1;
    chk("rst_Q", int'(Q), 9);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tc", int'(tc), 0);
    rst = 1'b1;

    // One-shot count 9..0 then DONE with a single tc
    reload = 1'b0;
    step(1, 0, 0, 0, 0);
    chk("start_Q", int'(Q), 9);
    chk("start_busy", int'(busy), 1);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 1, 0, 0);
      chk("oneshot_Q", int'(Q), 8 - i);
      chk("oneshot_tc", int'(tc), 0);
    end
    step(0, 0, 1, 0, 0);
    chk("term_tc", int'(tc), 1);
    chk("term_done", int'(done), 1);
    chk("term_Q", int'(Q), 0);
    step(0, 0, 1, 0, 0);
    chk("post_tc", int'(tc), 0);
    chk("post_done", int'(done), 1);

    // Auto-reload: restart from DONE, 25 ticks, tc on ticks 10 and 20
    reload = 1'b1;
    step(1, 0, 0, 0, 0);
    chk("restart_Q", int'(Q), 9);
    tc_cnt = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(0, 0, 1, 0, 0);
      tc_cnt += int'(tc);
      if (!busy) busy_ok = 1'b0;
    end
    chk("reload_tc_count", tc_cnt, 2);
    chk("reload_busy", int'(busy_ok), 1);
    chk("reload_Q", int'(Q), 4);
    step(1, 0, 1, 0, 0);
    chk("run_start_ignored_Q", int'(Q), 3);
    step(0, 1, 1, 0, 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_Q", int'(Q), 3);

    // Clamped loads, then one-shot from 3
    reload = 1'b0;
    step(0, 0, 0, 1, 4'd15);
    chk("clamp_Q", int'(Q), 9);
    step(0, 0, 0, 1, 4'd3);
    chk("load3_Q", int'(Q), 3);
    step(1, 0, 0, 0, 0);
    tc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0);
      tc_cnt += int'(tc);
    end
    chk("short_tc_count", tc_cnt, 1);
    chk("short_done", int'(done), 1);

    // stop and load together at Q==0 with en: stop wins
    step(0, 0, 0, 1, 4'd0);
    chk("done_load_busy", int'(busy), 0);
    chk("done_load_done", int'(done), 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 4'd7);
    chk("stopload_Q", int'(Q), 0);
    chk("stopload_tc", int'(tc), 0);
    chk("stopload_busy", int'(busy), 0);

    // en toggling from 5
    step(0, 0, 0, 1, 4'd5);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0); chk("tog_Q0", int'(Q), 4);
    step(0, 0, 0, 0, 0); chk("tog_Q1", int'(Q), 4);
    step(0, 0, 1, 0, 0); chk("tog_Q2", int'(Q), 3);
    step(0, 0, 0, 0, 0); chk("tog_Q3", int'(Q), 3);
    chk("tog_busy", int'(busy), 1);
    chk("tog_tc", int'(tc), 0);

    // load in RUN beats en: no decrement, no tc
    step(0, 0, 1, 1, 4'd0);
    chk("runload_Q", int'(Q), 0);
    chk("runload_tc", int'(tc), 0);
    chk("runload_busy", int'(busy), 1);
    step(0, 0, 1, 0, 0);
    chk("runload_term_tc", int'(tc), 1);
    step(0, 1, 0, 0, 0);
    chk("done_stop_done", int'(done), 0);

    // Asynchronous reset mid-RUN at Q==4
    step(0, 0, 0, 1, 4'd4);
    step(1, 0, 0, 0, 0);
    chk("pre_rst_Q", int'(Q), 4);
    en = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_Q", int'(Q), 9);
    chk("arst_busy", int'(busy), 0);
    chk("arst_tc", int'(tc), 0);
    @(posedge clk);
    #1;
    chk("arst_hold_tc", int'(tc), 0);
    rst = 1'b1;
    step(1, 0, 0, 0, 0);
    chk("resume_Q", int'(Q), 9);
    chk("resume_busy", int'(busy), 1);
    step(0, 0, 1, 0, 0);
    chk("resume_dec_Q", int'(Q), 8);

    step(0, 0, 0, 0, 0);
    @(negedge clk);
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/modulo_n_down_timer.md
MODULO_N_DOWN_TIMER -- requirements
Module: modulo_n_down_timer

Interface
REQ-001 The block SHALL have parameter N, default 10: counter modulus; count range 0..N-1; N >= 2.
REQ-002 The block SHALL have parameter WIDTH, default 4: counter width; WIDTH >= clog2(N).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin or restart counting.
REQ-006 The block SHALL have port stop, input, 1 bit: abort counting and return to IDLE.
REQ-007 The block SHALL have port en, input, 1 bit: count-enable tick; one decrement per enabled cycle in RUN.
REQ-008 The block SHALL have port load, input, 1 bit: load counter from load_val.
REQ-009 The block SHALL have port load_val, input, WIDTH bits: value to load.
REQ-010 The block SHALL have port reload, input, 1 bit: 1 = auto-reload at terminal count; 0 = one-shot.
REQ-011 The block SHALL have port Q, output, WIDTH bits: current count, registered.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-013 The block SHALL have port done, output, 1 bit: high while in DONE.
REQ-014 The block SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.

Function
REQ-015 The block SHALL implement states IDLE, RUN and DONE; busy = (state==RUN); done = (state==DONE); both are decoded from registered state.
REQ-016 Loading SHALL clamp: Q <= (load_val > N-1) ? N-1 : load_val.
REQ-017 Input priority at every edge SHALL be: stop > load > start > en.
REQ-018 IDLE: load loads Q and stays in IDLE; start moves to RUN with Q unchanged; otherwise Q holds.
REQ-019 RUN, en=1, Q>0: Q <= Q-1.
REQ-020 RUN, en=1, Q==0: tc <= 1 for the next cycle; if reload=1, Q <= N-1 and the state stays RUN; if reload=0, Q stays 0 and the state moves to DONE.
REQ-021 RUN, en=0: Q and state hold, and tc <= 0.
REQ-022 RUN, stop=1: go to IDLE with Q held and no tc, even if Q==0 and en=1 in the same cycle.
REQ-023 RUN, load=1 without stop: Q loads the clamped value, the state stays RUN, and no decrement or tc occurs that cycle.
REQ-024 RUN, start=1 with no stop or load: ignored; counting continues per en.
REQ-025 DONE: start gives Q <= N-1 and RUN; load loads Q and goes to IDLE; stop goes to IDLE; otherwise hold with Q=0.
REQ-026 tc SHALL be 0 in every cycle not immediately following a qualifying terminal-count edge, so it is never high for two consecutive cycles unless en=1 and Q==0 recur on consecutive edges.
REQ-027 Q SHALL never hold a value > N-1.
REQ-028 All arithmetic SHALL be WIDTH bits wide.
REQ-029 Decrement SHALL never underflow, because Q==0 is handled by REQ-020.
REQ-030 The reload value SHALL be exactly N-1 regardless of the last load_val.

Reset
REQ-031 rst=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, Q=N-1, tc=0, busy=0, done=0.
REQ-032 Reset SHALL override all inputs.
REQ-033 Reset asserted mid-RUN SHALL abandon counting, and tc SHALL not pulse.
REQ-034 After rst returns high, the first active edge SHALL obey REQ-017..REQ-025 from IDLE.

Verification
REQ-035 Reset then start, en=1 continuous, reload=0, N=10 -> Q counts 9,8,...,0; tc high exactly one cycle after the Q==0 edge; done=1 with Q=0 thereafter.
REQ-036 reload=1, en=1 for 25 cycles in RUN, N=10 -> Q wraps 0->9; tc pulses once every 10 cycles; busy stays 1.
REQ-037 In IDLE, load=1, load_val=15 (N=10, WIDTH=4) -> Q=9; load_val=3 -> Q=3; start then 4 enabled ticks -> DONE with one tc.
REQ-038 In RUN at Q==0 with en=1, assert stop=1 and load=1 simultaneously -> IDLE, Q=0, tc=0; the load is ignored per priority.
REQ-039 en toggling 1,0,1,0 in RUN from Q=5 -> Q=4,4,3,3; busy=1; tc=0.
REQ-040 rst asserted asynchronously between edges mid-RUN at Q=4 -> Q=9 and IDLE immediately; no tc; start after release -> counting resumes from 9.
